// File: rtl/carrier_dds_if.sv
// carrier_dds control/sample bundle: tuning and phase controls in, samples and strobes out.
// master drives the controls, slave is the DDS itself.
interface carrier_dds_if #(
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              en;
    logic              sync_clr;
    logic              ftw_ld;
    logic [ACC_W-1:0]  ftw_in;
    logic [ADDR_W-1:0] pow_in;
    logic [DATA_W-1:0] sin_out;
    logic [DATA_W-1:0] cos_out;
    logic              out_valid;
    logic              wrap_out;

    modport master (
        output en, sync_clr, ftw_ld, ftw_in, pow_in,
        input  sin_out, cos_out, out_valid, wrap_out
    );

    modport slave (
        input  en, sync_clr, ftw_ld, ftw_in, pow_in,
        output sin_out, cos_out, out_valid, wrap_out
    );
endinterface

// File: rtl/carrier_dds.sv
// carrier_dds: phase accumulator + quarter-wave sine table, offset-binary out; CARRIER_QUAD_EN adds cos_out.
// Latency 2 clocks from en edge to sample; no backpressure, one sample launched per en cycle.
module carrier_dds #(
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    carrier_dds_if.slave dds
);
    localparam int N  = 1 << ADDR_W;
    localparam int QN = N / 4;
    localparam int JW = ADDR_W - 1;
    localparam int JN = 1 << JW;
    localparam logic [DATA_W-1:0] MID = {1'b0, {(DATA_W-1){1'b1}}};

    // Table padded to a power of two so every j index stays in range.
    function automatic logic [JN*DATA_W-1:0] build_q();
        logic [JN*DATA_W-1:0] v;
        real x, t, s;
        v = '0;
        for (int i = 0; i <= QN; i++) begin
            x = 6.283185307179586 * real'(i) / real'(N);
            s = x;
            t = x;
            for (int n = 1; n < 12; n++) begin
                t = -t * x * x / real'((2 * n) * (2 * n + 1));
                s = s + t;
            end
            v[i*DATA_W +: DATA_W] = DATA_W'($rtoi(s * real'(1 << (DATA_W - 1)) + 0.5));
        end
        return v;
    endfunction

    localparam logic [JN*DATA_W-1:0] Q_PACK = build_q();

    // Returns {negative, j}.
    function automatic logic [JW:0] fold(input logic [ADDR_W-1:0] k);
        logic [JW-1:0] r;
        r = {1'b0, k[ADDR_W-3:0]};
        return {k[ADDR_W-1], k[ADDR_W-2] ? (JW'(QN) - r) : r};
    endfunction

    function automatic logic [DATA_W-1:0] qlut(input logic [JW-1:0] j);
        return Q_PACK[int'(j)*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] to_samp(input logic neg, input logic [DATA_W-1:0] q);
        logic [DATA_W:0] sum;
        sum = neg ? ({1'b0, MID} - {1'b0, q}) : ({1'b0, MID} + {1'b0, q});
        if (neg && sum[DATA_W]) begin
            return '0;
        end
        return sum[DATA_W-1:0];
    endfunction

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  ftw;
    logic              cy;
    logic [ADDR_W-1:0] k_sin;
    logic [JW:0]       f_sin;
    logic              s1_vld;
    logic              s1_wrap;
    logic              s1_neg;
    logic [JW-1:0]     s1_j;

    assign k_sin = acc[ACC_W-1 -: ADDR_W] + dds.pow_in;
    assign f_sin = fold(k_sin);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ftw <= '0;
            acc <= '0;
            cy  <= 1'b0;
        end else begin
            if (dds.ftw_ld) begin
                ftw <= dds.ftw_in;
            end
            if (dds.sync_clr) begin
                acc <= '0;
                cy  <= 1'b0;
            end else if (dds.en) begin
                {cy, acc} <= {1'b0, acc} + {1'b0, ftw};
            end
        end
    end

    // cy marks that the current acc came from an overflowing add.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld  <= 1'b0;
            s1_wrap <= 1'b0;
            s1_neg  <= 1'b0;
            s1_j    <= '0;
        end else begin
            s1_vld <= dds.en;
            if (dds.en) begin
                s1_wrap <= cy;
                s1_neg  <= f_sin[JW];
                s1_j    <= f_sin[JW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dds.sin_out   <= MID;
            dds.out_valid <= 1'b0;
            dds.wrap_out  <= 1'b0;
        end else begin
            dds.out_valid <= s1_vld;
            dds.wrap_out  <= s1_vld & s1_wrap;
            if (s1_vld) begin
                dds.sin_out <= to_samp(s1_neg, qlut(s1_j));
            end
        end
    end

`ifdef CARRIER_QUAD_EN
    logic [ADDR_W-1:0] k_cos;
    logic [JW:0]       f_cos;
    logic              c1_neg;
    logic [JW-1:0]     c1_j;

    assign k_cos = k_sin + ADDR_W'(QN);
    assign f_cos = fold(k_cos);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c1_neg      <= 1'b0;
            c1_j        <= '0;
            dds.cos_out <= MID;
        end else begin
            if (dds.en) begin
                c1_neg <= f_cos[JW];
                c1_j   <= f_cos[JW-1:0];
            end
            if (s1_vld) begin
                dds.cos_out <= to_samp(c1_neg, qlut(c1_j));
            end
        end
    end
`else
    assign dds.cos_out = MID;
`endif

endmodule

// File: tb/tb_carrier_dds.sv
// Bench for carrier_dds: directed test-plan scenarios plus random stimulus against a sine-based reference.
// The reference computes samples from $sin of the ideal phase, delayed by the two-clock latency.
module tb_carrier_dds;
    localparam int ACC_W  = 24;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int N      = 1 << ADDR_W;
    localparam int MID    = (1 << (DATA_W - 1)) - 1;
    localparam longint MOD = longint'(1) << ACC_W;
    localparam real PI = 3.141592653589793;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   n_chk   = 0;
    int   n_err   = 0;
    bit   logging = 1'b0;
    int   log_s[$];
    bit   log_w[$];

    carrier_dds_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

    carrier_dds #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dds     (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int ref_samp(input int k);
        real v;
        int  mag;
        v   = real'(1 << (DATA_W - 1)) * $sin(2.0 * PI * real'(k % N) / real'(N));
        mag = $rtoi(((v < 0.0) ? -v : v) + 0.5);
        if (v >= 0.0) return MID + mag;
        return (MID - mag < 0) ? 0 : MID - mag;
    endfunction

    // Reference: ideal phase accumulator, sample taken from the phase before each en edge.
    longint macc, mftw;
    bit     mcy;
    bit     p_valid, p_wrap, m_valid, m_wrap;
    int     p_sin, p_cos, m_sin, m_cos;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            macc <= 0; mftw <= 0; mcy <= 0;
            p_valid <= 0; p_wrap <= 0; p_sin <= MID; p_cos <= MID;
            m_valid <= 0; m_wrap <= 0; m_sin <= MID; m_cos <= MID;
        end else begin
            m_valid <= p_valid;
            m_wrap  <= p_valid && p_wrap;
            if (p_valid) begin
                m_sin <= p_sin;
                m_cos <= p_cos;
            end
            p_valid <= dif.en;
            if (dif.en) begin
                p_sin  <= ref_samp(int'(macc >> (ACC_W - ADDR_W)) + int'(dif.pow_in));
                p_cos  <= ref_samp(int'(macc >> (ACC_W - ADDR_W)) + int'(dif.pow_in) + N / 4);
                p_wrap <= mcy;
            end
            if (dif.ftw_ld) mftw <= longint'(dif.ftw_in);
            if (dif.sync_clr) begin
                macc <= 0;
                mcy  <= 0;
            end else if (dif.en) begin
                macc <= (macc + mftw) % MOD;
                mcy  <= (macc + mftw) >= MOD;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", longint'(dif.out_valid), longint'(m_valid));
        chk("wrap", longint'(dif.wrap_out), longint'(m_wrap));
        chk("sin", longint'(dif.sin_out), longint'(m_sin));
`ifdef CARRIER_QUAD_EN
        chk("cos", longint'(dif.cos_out), longint'(m_cos));
`else
        chk("cos_tied", longint'(dif.cos_out), longint'(MID));
`endif
        if (logging && dif.out_valid) begin
            log_s.push_back(int'(dif.sin_out));
            log_w.push_back(dif.wrap_out);
        end
    end

    task automatic step(input logic e, input logic sc, input logic ld,
                        input logic [ACC_W-1:0] f, input logic [ADDR_W-1:0] p);
        dif.en       = e;
        dif.sync_clr = sc;
        dif.ftw_ld   = ld;
        dif.ftw_in   = f;
        dif.pow_in   = p;
        @(posedge clk);
        #1;
    endtask

    localparam logic [ACC_W-1:0] F19 = ACC_W'(1 << 19);
    localparam logic [ACC_W-1:0] F20 = ACC_W'(1 << 20);

    initial begin
        dif.en = 0; dif.sync_clr = 0; dif.ftw_ld = 0; dif.ftw_in = '0; dif.pow_in = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sin", longint'(dif.sin_out), longint'(MID));
        chk("rst_valid", longint'(dif.out_valid), 0);
        chk("rst_wrap", longint'(dif.wrap_out), 0);
        chk("rst_cos", longint'(dif.cos_out), longint'(MID));
        reset_n = 1'b1;

        // Basic sweep at ftw = 2^19: 32 samples per period.
        step(0, 0, 1, F19, '0);
        logging = 1'b1;
        repeat (70) step(1, 0, 0, '0, '0);
        logging = 1'b0;
        chk("nsamp_ge65", longint'(log_s.size() >= 65), 1);
        if (log_s.size() >= 65) begin
            chk("smp0", log_s[0], 127);
            chk("smp1", log_s[1], 152);
            chk("smp2", log_s[2], 176);
            chk("smp3", log_s[3], 198);
            chk("smp8", log_s[8], 255);
            chk("smp16", log_s[16], 127);
            chk("smp24", log_s[24], 0);
            chk("wrap0", longint'(log_w[0]), 0);
            chk("wrap31", longint'(log_w[31]), 0);
            chk("wrap32", longint'(log_w[32]), 1);
            chk("wrap33", longint'(log_w[33]), 0);
            chk("wrap64", longint'(log_w[64]), 1);
        end

        // ftw = 0, pow = 8: constant peak.
        step(0, 1, 1, '0, 5'd8);
        repeat (8) step(1, 0, 0, '0, 5'd8);
        chk("const_sin", longint'(dif.sin_out), 255);
        chk("const_valid", longint'(dif.out_valid), 1);
        chk("const_wrap", longint'(dif.wrap_out), 0);
`ifdef CARRIER_QUAD_EN
        chk("const_cos", longint'(dif.cos_out), 127);
`endif

        // Mid-stream tuning change, then en gaps.
        step(0, 1, 1, F19, '0);
        repeat (3) step(1, 0, 0, '0, '0);
        step(1, 0, 1, F20, '0);
        repeat (6) step(1, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        repeat (3) step(0, 0, 0, '0, '0);

        // sync_clr together with en at nonzero phase.
        repeat (4) step(1, 0, 0, '0, '0);
        step(1, 1, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        chk("clr_sin", longint'(dif.sin_out), 127);
        chk("clr_wrap", longint'(dif.wrap_out), 0);

        // Asynchronous reset mid-stream.
        repeat (5) step(1, 0, 0, '0, '0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_sin", longint'(dif.sin_out), longint'(MID));
        chk("arst_valid", longint'(dif.out_valid), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) step(1, 0, 0, '0, '0);
        chk("post_rst_sin", longint'(dif.sin_out), 127);
        chk("post_rst_valid", longint'(dif.out_valid), 1);

        // Random stimulus.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0,
                 $urandom_range(0, 31) == 0,
                 ($urandom_range(0, 3) == 0) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 1 << 21)),
                 ADDR_W'($urandom));
        end
        step(0, 0, 0, '0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
